// File: rtl/fifo_rd_streamer_pkg.sv
// Shared widths, stream word type and width helpers for the FIFO read-side streamer.
package fifo_rd_streamer_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned SKID_D_DEF = 2;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef logic [DATA_W_DEF-1:0] data_t;

  // Width holding 0..depth (buffer occupancy).
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width holding occ + inflight without overflow (credit arithmetic).
  function automatic int unsigned credit_w(input int unsigned depth);
    return $clog2(depth + 2) + 1;
  endfunction

  localparam int unsigned CRD_W_DEF = credit_w(SKID_D_DEF);

endpackage

// File: rtl/fifo_rd_streamer_skid_buf.sv
// Circular output buffer between FIFO capture and the stream head.
module fifo_rd_skid_buf
  import fifo_rd_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = SKID_D_DEF,
  parameter int unsigned OCC_W  = occ_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  output logic [DATA_W-1:0] rdata,
  output logic [OCC_W-1:0]  occ,
  output logic              not_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[tail] <= wdata;
        tail      <= ptr_inc(tail);
      end
      if (rd) head <= ptr_inc(head);
      // Simultaneous write and read leaves occupancy unchanged.
      case ({wr, rd})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign rdata     = mem[head];
  assign not_empty = (occ != '0);

  // The credit rule upstream must keep the buffer from overflowing or underrunning.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(wr && !rd && (occ == OCC_W'(DEPTH))));
  a_no_underrun : assert property (@(posedge clk) disable iff (rst)
    !(rd && (occ == '0)));

endmodule

// File: rtl/fifo_rd_streamer.sv
// FIFO read-side drain engine: issues rd_en, captures data_out a cycle later,
// and presents words on a valid/ready stream with drain counting and underflow flagging.
module fifo_rd_streamer
  import fifo_rd_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SKID_D = SKID_D_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] data_out,
  input  logic              empty,
  input  logic              underflow,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  drain_cnt,
  output logic              err_underflow
);

  localparam int unsigned OCC_W = occ_w(SKID_D);
  localparam int unsigned CRD_W = credit_w(SKID_D);

  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic             not_empty;
  logic             pop;
  logic             capture;
  logic             flag_uf;
  logic [CRD_W-1:0] outstanding;

  assign pop     = m_valid & m_ready;
  assign capture = inflight & ~underflow;
  assign flag_uf = inflight & underflow;

  // Credit: words buffered plus the one in flight, net of this cycle's pop.
  assign outstanding = CRD_W'(occ) + CRD_W'(inflight) - CRD_W'(pop);
  assign rd_en       = enable & ~empty & ~rst & (outstanding < CRD_W'(SKID_D));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= rd_en;
  end

  fifo_rd_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_D),
    .OCC_W  (OCC_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .wr        (capture),
    .wdata     (data_out),
    .rd        (pop),
    .rdata     (m_data),
    .occ       (occ),
    .not_empty (not_empty)
  );

  assign m_valid = not_empty;

  // Handshake counter; clr outranks a coincident pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      drain_cnt <= '0;
    else if (clr) drain_cnt <= '0;
    else if (pop) drain_cnt <= drain_cnt + 1'b1;
  end

  // Sticky underflow flag; a flagged capture outranks a coincident clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_underflow <= 1'b0;
    else if (flag_uf) err_underflow <= 1'b1;
    else if (clr)     err_underflow <= 1'b0;
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Randomized bench for fifo_rd_streamer with a queue-based FIFO and stream reference model.
module tb_fifo_rd_streamer;

  localparam int SKID_D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clr;
  logic        rd_en;
  logic [15:0] data_out;
  logic        empty;
  logic        underflow;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] drain_cnt;
  logic        err_underflow;

  int checks   = 0;
  int failures = 0;

  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic        drv_valid = 1'b0;
  logic        drv_uf    = 1'b0;
  logic        force_ne  = 1'b0;
  logic [15:0] exp_cnt   = 16'd0;
  logic        exp_err   = 1'b0;
  int cyc = 0, n_rd = 0, n_pop = 0, first_rd = -1, last_rd = -1, first_pop = -1;

  fifo_rd_streamer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .clr           (clr),
    .rd_en         (rd_en),
    .data_out      (data_out),
    .empty         (empty),
    .underflow     (underflow),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .drain_cnt     (drain_cnt),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic set_empty();
    empty = (fifo_q.size() == 0) && !force_ne;
  endtask

  task automatic clear_trackers();
    n_rd = 0; n_pop = 0; first_rd = -1; last_rd = -1; first_pop = -1;
  endtask

  // One clock: compare DUT against the model at negedge, then play the FIFO side.
  task automatic tick();
    int cap, outst;
    logic exp_valid, exp_pop, exp_rd, nv, nuf;
    logic [15:0] nd;
    @(negedge clk);
    cap       = exp_q.size() - ((drv_valid && !drv_uf) ? 1 : 0);
    exp_valid = (cap > 0);
    outst     = cap + (drv_valid ? 1 : 0);
    exp_pop   = exp_valid && m_ready;
    exp_rd    = enable && !empty && !rst && ((outst - (exp_pop ? 1 : 0)) < SKID_D);
    checks++;
    if (m_valid !== exp_valid) begin
      failures++; $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, m_valid, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (m_data !== exp_q[0]) begin
        failures++; $display("FAIL m_data cyc=%0d got=%h exp=%h", cyc, m_data, exp_q[0]);
      end
    end
    checks++;
    if (rd_en !== exp_rd) begin
      failures++; $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, exp_rd);
    end
    checks++;
    if (drain_cnt !== exp_cnt) begin
      failures++; $display("FAIL drain_cnt cyc=%0d got=%h exp=%h", cyc, drain_cnt, exp_cnt);
    end
    checks++;
    if (err_underflow !== exp_err) begin
      failures++; $display("FAIL err_underflow cyc=%0d got=%b exp=%b", cyc, err_underflow, exp_err);
    end
    if (exp_pop) begin
      void'(exp_q.pop_front());
      n_pop++;
      if (first_pop < 0) first_pop = cyc;
    end
    if (clr) exp_cnt = 16'd0;
    else if (exp_pop) exp_cnt = exp_cnt + 16'd1;
    if (drv_valid && drv_uf) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
    nv = (rd_en === 1'b1); nuf = 1'b0; nd = 16'($urandom);
    if (nv) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      if (fifo_q.size() > 0) begin
        nd = fifo_q.pop_front();
        exp_q.push_back(nd);
      end else nuf = 1'b1;
    end
    cyc++;
    @(posedge clk); #1;
    drv_valid = nv;
    drv_uf    = nuf;
    data_out  = nd;
    underflow = nv ? nuf : 1'($urandom);
    set_empty();
  endtask

  task automatic drain();
    int k = 0;
    enable = 1'b1; m_ready = 1'b1;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || drv_valid) && k < 300) begin
      tick(); k++;
    end
    checks++;
    if (k >= 300) begin
      failures++; $display("FAIL drain_timeout got=%0d left exp=0", exp_q.size() + fifo_q.size());
    end
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks += 5;
    if (rd_en !== 1'b0)         begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    if (m_valid !== 1'b0)       begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    if (m_data !== 16'h0)       begin failures++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
    if (drain_cnt !== 16'h0)    begin failures++; $display("FAIL reset_drain_cnt got=%h exp=0", drain_cnt); end
    if (err_underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    do_clr();
    clear_trackers();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(16'(i));
    set_empty();
    enable = 1'b1; m_ready = 1'b1;
    repeat (12) tick();
    checks += 5;
    if (n_rd != 8) begin failures++; $display("FAIL stream_rd_count got=%0d exp=8", n_rd); end
    if (last_rd - first_rd != 7) begin failures++; $display("FAIL stream_rd_consecutive got=%0d exp=7", last_rd - first_rd); end
    if (first_pop != first_rd + 2) begin failures++; $display("FAIL stream_latency got=%0d exp=%0d", first_pop, first_rd + 2); end
    if (n_pop != 8) begin failures++; $display("FAIL stream_pops got=%0d exp=8", n_pop); end
    if (drain_cnt !== 16'd8) begin failures++; $display("FAIL stream_drain_cnt got=%0d exp=8", drain_cnt); end
  endtask

  task automatic test_backpressure();
    clear_trackers();
    for (int i = 1; i <= 4; i++) fifo_q.push_back(16'(i));
    set_empty();
    enable = 1'b1; m_ready = 1'b0;
    repeat (5) tick();
    checks += 2;
    if (n_rd != 2) begin failures++; $display("FAIL bp_rd_stop got=%0d exp=2", n_rd); end
    if (m_valid !== 1'b1 || m_data !== 16'h0001) begin
      failures++; $display("FAIL bp_hold got=%b/%h exp=1/0001", m_valid, m_data);
    end
    m_ready = 1'b1; n_pop = 0;
    repeat (4) tick();
    checks++;
    if (n_pop != 4) begin failures++; $display("FAIL bp_no_gaps got=%0d exp=4", n_pop); end
    drain();
  endtask

  task automatic test_underflow();
    enable = 1'b1; m_ready = 1'b1;
    force_ne = 1'b1; set_empty(); force_ne = 1'b0;
    n_pop = 0;
    tick(); tick(); tick();
    checks += 2;
    if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%b exp=1", err_underflow); end
    if (n_pop != 0) begin failures++; $display("FAIL uf_word_emitted got=%0d exp=0", n_pop); end
    do_clr(); tick();
    checks++;
    if (err_underflow !== 1'b0) begin failures++; $display("FAIL uf_clr got=%b exp=0", err_underflow); end
    // Set and clear in the same cycle: the flag stays set.
    clr = 1'b1; force_ne = 1'b1; set_empty(); force_ne = 1'b0;
    tick(); tick(); clr = 1'b0; tick();
    checks++;
    if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_set_wins got=%b exp=1", err_underflow); end
    do_clr(); tick();
  endtask

  task automatic test_enable_drop();
    clear_trackers();
    for (int i = 1; i <= 6; i++) fifo_q.push_back(16'(16'hA0 + i));
    set_empty();
    enable = 1'b1; m_ready = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    repeat (5) tick();
    checks += 2;
    if (n_rd != 3) begin failures++; $display("FAIL en_drop_rd got=%0d exp=3", n_rd); end
    if (n_pop != 3) begin failures++; $display("FAIL en_drop_delivered got=%0d exp=3", n_pop); end
    drain();
    checks++;
    if (n_rd != 6) begin failures++; $display("FAIL en_resume got=%0d exp=6", n_rd); end
  endtask

  task automatic test_counter();
    int k = 0;
    int p0;
    do_clr();
    for (int i = 0; i < 65545; i++) fifo_q.push_back(16'($urandom));
    set_empty();
    enable = 1'b1; m_ready = 1'b1;
    while (exp_cnt != 16'hFFFF && k < 70000) begin tick(); k++; end
    checks += 2;
    if (k >= 70000) begin failures++; $display("FAIL cnt_timeout got=%h exp=ffff", exp_cnt); end
    if (drain_cnt !== 16'hFFFF) begin failures++; $display("FAIL cnt_preset got=%h exp=ffff", drain_cnt); end
    tick();
    checks++;
    if (drain_cnt !== 16'h0000) begin failures++; $display("FAIL cnt_wrap got=%h exp=0000", drain_cnt); end
    tick();
    p0 = n_pop;
    clr = 1'b1; tick(); clr = 1'b0;
    checks += 2;
    if (n_pop != p0 + 1) begin failures++; $display("FAIL cnt_clr_pop got=%0d exp=%0d", n_pop - p0, 1); end
    if (drain_cnt !== 16'h0000) begin failures++; $display("FAIL cnt_clr_prio got=%h exp=0000", drain_cnt); end
    drain();
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 6; i++) fifo_q.push_back(16'(16'hC0 + i));
    set_empty();
    enable = 1'b1; m_ready = 1'b1;
    repeat (3) tick();
    m_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (m_valid !== 1'b0)    begin failures++; $display("FAIL arst_m_valid got=%b exp=0", m_valid); end
    if (rd_en !== 1'b0)      begin failures++; $display("FAIL arst_rd_en got=%b exp=0", rd_en); end
    if (drain_cnt !== 16'h0) begin failures++; $display("FAIL arst_drain_cnt got=%h exp=0", drain_cnt); end
    if (m_data !== 16'h0)    begin failures++; $display("FAIL arst_m_data got=%h exp=0", m_data); end
    exp_q.delete();
    drv_valid = 1'b0; drv_uf = 1'b0; underflow = 1'b0;
    exp_cnt = 16'd0; exp_err = 1'b0;
    tick(); tick();
    rst = 1'b0; enable = 1'b0; m_ready = 1'b1; n_pop = 0;
    repeat (4) tick();
    checks++;
    if (n_pop != 0) begin failures++; $display("FAIL arst_stale got=%0d exp=0", n_pop); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if (fifo_q.size() < 3 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 6)) fifo_q.push_back(16'($urandom));
      set_empty();
      enable  = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      clr     = ($urandom_range(0, 19) == 0);
      tick();
    end
    clr = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clr = 1'b0; m_ready = 1'b0;
    data_out = 16'h0; underflow = 1'b0; empty = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_underflow();
    test_enable_drop();
    test_async_reset();
    test_random();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
